// File: rtl/ddp_pkg.sv
// Shared DDP beat format: field positions and widths of the 265-bit packet beat
// used by the assembler, loop and cut blocks.
package ddp_pkg;

    localparam int BEAT_W  = 265;
    localparam int DATA_W  = 256;
    localparam int BC_W    = 7;
    localparam int SOP_BIT = 264;
    localparam int EOP_BIT = 263;
    localparam int BC_MSB  = 262;
    localparam int BC_LSB  = 256;

    // Byte count of a completely filled beat.
    localparam logic [BC_W-1:0] FULL_BC = 7'd32;

    // Segment beat counter width: holds 1..16.
    localparam int SEG_CNT_W = 5;
    localparam logic [SEG_CNT_W-1:0] SEG_MAX_BEATS = 5'd16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } ddp_state_e;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [BC_W-1:0]   bc;
        logic [DATA_W-1:0] data;
    } ddp_beat_t;

endpackage

// File: rtl/ddp_cut.sv
// DDP packet cutter: forwards packet beats from a first-word-fall-through FIFO
// through one output register, splitting long packets into segments of at most
// cfgMaxSegBeats beats by forcing eop/sop at segment boundaries.
module ddp_cut
    import ddp_pkg::*;
#(
    parameter int MAX_SEG_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BEAT_W-1:0]    ddpPktDataIn,
    input  logic                 ddpPktEmpty,
    output logic                 ddpPktPop,
    input  logic [MAX_SEG_W-1:0] cfgMaxSegBeats,
    output logic [BEAT_W-1:0]    segDataOut,
    output logic                 segValid,
    input  logic                 segReady,
    output logic                 segPktEnd,
    output logic [31:0]          pktCount,
    output logic                 errNoSop,
    output logic                 errEarlySop
);

    ddp_state_e             r_state;
    logic [SEG_CNT_W-1:0]   r_cnt;
    logic [SEG_CNT_W-1:0]   r_max;
    logic                   r_fsop;

    ddp_beat_t              w_in;
    ddp_beat_t              w_out;
    logic                   w_pop;
    logic                   w_emit;
    logic                   w_force;
    logic [SEG_CNT_W-1:0]   w_cfgMax;
    logic [SEG_CNT_W-1:0]   w_max;
    logic [SEG_CNT_W-1:0]   w_cnt;

    // Pop whenever the output register is free or being drained; held off in reset
    // so no beat is lost while the block is cleared.
    assign w_pop     = reset && !ddpPktEmpty && (!segValid || segReady);
    assign ddpPktPop = w_pop;

    // Decode the head beat and build the (possibly cut) output beat.
    always_comb begin
        w_in = ddp_beat_t'(ddpPktDataIn);
        // 0 (and anything beyond the supported range) means the maximum segment length.
        if ((cfgMaxSegBeats == '0) || (32'(cfgMaxSegBeats) > 32'd16)) begin
            w_cfgMax = SEG_MAX_BEATS;
        end else begin
            w_cfgMax = SEG_CNT_W'(cfgMaxSegBeats);
        end
        // A sop beat uses the freshly sampled limit; later beats use the stored one.
        w_max   = w_in.sop ? w_cfgMax : r_max;
        w_cnt   = (w_in.sop || r_fsop) ? SEG_CNT_W'(1) : r_cnt + SEG_CNT_W'(1);
        // Stray non-sop beats outside a packet are dropped.
        w_emit  = (r_state == ST_IN_PKT) || w_in.sop;
        w_force = !w_in.eop && (w_cnt == w_max);
        w_out     = w_in;
        w_out.sop = w_in.sop || r_fsop;
        if (w_force) begin
            w_out.eop = 1'b1;
            w_out.bc  = FULL_BC;
        end
    end

    // Packet state, segment counter, output register and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_max       <= '0;
            r_fsop      <= 1'b0;
            segDataOut  <= '0;
            segValid    <= 1'b0;
            segPktEnd   <= 1'b0;
            pktCount    <= '0;
            errNoSop    <= 1'b0;
            errEarlySop <= 1'b0;
        end else begin
            errNoSop    <= 1'b0;
            errEarlySop <= 1'b0;
            if (w_pop) begin
                if (w_emit) begin
                    segValid   <= 1'b1;
                    segDataOut <= w_out;
                    segPktEnd  <= w_in.eop;
                    r_cnt      <= w_cnt;
                    r_fsop     <= w_force;
                    if (w_in.sop) begin
                        r_max <= w_cfgMax;
                    end
                    if (w_in.sop && (r_state == ST_IN_PKT)) begin
                        errEarlySop <= 1'b1;
                    end
                    if (w_in.eop) begin
                        r_state  <= ST_IDLE;
                        pktCount <= pktCount + 32'd1;
                    end else begin
                        r_state  <= ST_IN_PKT;
                    end
                end else begin
                    segValid  <= 1'b0;
                    segPktEnd <= 1'b0;
                    errNoSop  <= 1'b1;
                end
            end else if (segReady) begin
                segValid  <= 1'b0;
                segPktEnd <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddp_cut.sv
// Testbench for ddp_cut: FIFO model drives beats, expected beats are queued as
// stimulus is issued and a monitor compares every accepted output beat.
module tb_ddp_cut;

    logic         clock;
    logic         reset;
    logic [264:0] ddpPktDataIn;
    logic         ddpPktEmpty;
    logic         ddpPktPop;
    logic [4:0]   cfgMaxSegBeats;
    logic [264:0] segDataOut;
    logic         segValid;
    logic         segReady;
    logic         segPktEnd;
    logic [31:0]  pktCount;
    logic         errNoSop;
    logic         errEarlySop;

    typedef struct {
        logic [264:0] beat;
        logic         pend;
    } exp_t;

    logic [264:0] fifo_q[$];
    exp_t         exp_q[$];

    int  n_chk = 0;
    int  n_fail = 0;
    int  n_obs = 0;
    int  n_nosop = 0;
    int  n_early = 0;
    int  exp_pkts = 0;
    bit  rnd_ready = 0;

    ddp_cut #(.MAX_SEG_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ddpPktDataIn   (ddpPktDataIn),
        .ddpPktEmpty    (ddpPktEmpty),
        .ddpPktPop      (ddpPktPop),
        .cfgMaxSegBeats (cfgMaxSegBeats),
        .segDataOut     (segDataOut),
        .segValid       (segValid),
        .segReady       (segReady),
        .segPktEnd      (segPktEnd),
        .pktCount       (pktCount),
        .errNoSop       (errNoSop),
        .errEarlySop    (errEarlySop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [264:0] act, input logic [264:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [264:0] mk(input logic sop, input logic eop,
                                        input logic [6:0] bc, input logic [31:0] d);
        return {sop, eop, bc, {8{d}}};
    endfunction

    task automatic push_exp(input logic [264:0] b, input logic pend);
        exp_t e;
        e.beat = b;
        e.pend = pend;
        exp_q.push_back(e);
    endtask

    // Packet of n beats; expected output cut into segments of seglen beats.
    task automatic send_pkt(input int n, input logic [6:0] lastbc, input int dbase, input int seglen);
        for (int i = 0; i < n; i++) begin
            logic       last;
            logic       esop;
            logic       eeop;
            logic [6:0] bc;
            last = (i == n - 1);
            bc   = last ? lastbc : 7'd32;
            esop = ((i % seglen) == 0);
            eeop = last || ((i % seglen) == seglen - 1);
            fifo_q.push_back(mk(i == 0, last, bc, 32'(dbase + i)));
            push_exp(mk(esop, eeop, (eeop && !last) ? 7'd32 : bc, 32'(dbase + i)), last);
        end
        exp_pkts++;
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 0;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clock);
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !segValid) done = 1;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d beats pending, expected 0", nm, exp_q.size());
        end
        chk({nm, "_pktCount"}, 265'(pktCount), 265'(exp_pkts));
    endtask

    // FIFO model: present head beat, remove it after a popping edge.
    initial begin
        bit p;
        ddpPktEmpty  = 1'b1;
        ddpPktDataIn = '0;
        segReady     = 1'b1;
        forever begin
            @(negedge clock);
            p = ddpPktPop;
            @(posedge clock);
            #1;
            if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
            ddpPktEmpty  = (fifo_q.size() == 0);
            ddpPktDataIn = ddpPktEmpty ? '0 : fifo_q[0];
            segReady     = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare accepted beats, check stability under stall, count error pulses.
    initial begin
        bit           hold_v;
        logic [264:0] hold_d;
        logic         hold_e;
        hold_v = 0;
        hold_d = '0;
        hold_e = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                hold_v = 0;
            end else begin
                if (errNoSop) n_nosop++;
                if (errEarlySop) n_early++;
                if (hold_v) begin
                    chk("stall_valid", 265'(segValid), 265'(1));
                    chk("stall_data", segDataOut, hold_d);
                    chk("stall_pktend", 265'(segPktEnd), 265'(hold_e));
                end
                hold_v = segValid && !segReady;
                hold_d = segDataOut;
                hold_e = segPktEnd;
                if (hold_v) chk("stall_pop", 265'(ddpPktPop), 265'(0));
                if (segValid && segReady) begin
                    n_obs++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", segDataOut, '0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("beat", segDataOut, e.beat);
                        chk("pktend", 265'(segPktEnd), 265'(e.pend));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        cfgMaxSegBeats = 5'd4;
        repeat (3) @(negedge clock);
        chk("rst_segValid", 265'(segValid), 265'(0));
        chk("rst_segDataOut", segDataOut, '0);
        chk("rst_segPktEnd", 265'(segPktEnd), 265'(0));
        chk("rst_pktCount", 265'(pktCount), 265'(0));
        chk("rst_pop", 265'(ddpPktPop), 265'(0));
        chk("rst_errs", 265'({errNoSop, errEarlySop}), 265'(0));
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 10 beats, max 4: eop on beats 4, 8, 10.
        cfgMaxSegBeats = 5'd4;
        n_early = 0;
        send_pkt(10, 7'd5, 32'h100, 4);
        drain("seg4");
        chk("seg4_noEarly", 265'(n_early), 265'(0));

        // max 0 means 16: one segment.
        cfgMaxSegBeats = 5'd0;
        send_pkt(16, 7'd32, 32'h200, 16);
        drain("seg16");

        // Stray beat in IDLE then a 1-beat packet.
        cfgMaxSegBeats = 5'd4;
        n_nosop = 0;
        fifo_q.push_back(mk(1'b0, 1'b0, 7'd32, 32'h300));
        send_pkt(1, 7'd17, 32'h310, 4);
        drain("nosop");
        chk("nosop_pulses", 265'(n_nosop), 265'(1));

        // Max 1: every beat is its own segment.
        cfgMaxSegBeats = 5'd1;
        send_pkt(3, 7'd2, 32'h350, 1);
        drain("seg1");

        // Random backpressure across three back-to-back packets.
        cfgMaxSegBeats = 5'd3;
        rnd_ready = 1;
        send_pkt(5, 7'd11, 32'h400, 3);
        send_pkt(2, 7'd1, 32'h410, 3);
        send_pkt(7, 7'd20, 32'h420, 3);
        drain("stall");
        rnd_ready = 0;

        // sop on the 3rd beat of an open packet.
        cfgMaxSegBeats = 5'd4;
        n_early = 0;
        fifo_q.push_back(mk(1'b1, 1'b0, 7'd32, 32'h500));
        push_exp(mk(1'b1, 1'b0, 7'd32, 32'h500), 1'b0);
        fifo_q.push_back(mk(1'b0, 1'b0, 7'd32, 32'h501));
        push_exp(mk(1'b0, 1'b0, 7'd32, 32'h501), 1'b0);
        send_pkt(6, 7'd9, 32'h510, 4);
        drain("early");
        chk("early_pulses", 265'(n_early), 265'(1));

        // Reset in the middle of the second segment.
        begin
            int  base;
            bit  hit;
            base = n_obs;
            hit  = 0;
            send_pkt(10, 7'd5, 32'h600, 4);
            for (int k = 0; k < 200 && !hit; k++) begin
                @(negedge clock);
                if (n_obs >= base + 6) hit = 1;
            end
            chk("rst_mid_reached", 265'(hit), 265'(1));
            @(posedge clock);
            #2;
            reset = 1'b0;
            fifo_q.delete();
            exp_q.delete();
            exp_pkts = 0;
            #1;
            chk("rst_mid_segValid", 265'(segValid), 265'(0));
            chk("rst_mid_pktCount", 265'(pktCount), 265'(0));
            repeat (3) @(negedge clock);
            reset = 1'b1;
            repeat (2) @(negedge clock);
            send_pkt(10, 7'd5, 32'h700, 4);
            drain("after_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
